// File: rtl/peak_scan_sequencer_if.sv
// Handshake and buffer-port bundle for the peak scan sequencer.
// The slave side is the sequencer; the master side is its environment (buffer, packer, control).
interface peak_scan_if #(
  parameter int DATA_W = 32,
  parameter int BIN_W  = 5,
  parameter int PT_W   = 10
);
  logic                  start;
  logic                  abort;
  logic [BIN_W-1:0]      bin_count;
  logic                  buf_ready;
  logic                  rd_en;
  logic [BIN_W+PT_W-1:0] rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  pk_valid;
  logic                  pk_ready;
  logic [DATA_W-1:0]     pk_value;
  logic [PT_W-1:0]       pk_addr;
  logic [BIN_W-1:0]      pk_bin;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, abort, bin_count, buf_ready, rd_data, pk_ready,
    output rd_en, rd_addr, pk_valid, pk_value, pk_addr, pk_bin, busy, done
  );

  modport master (
    output start, abort, bin_count, buf_ready, rd_data, pk_ready,
    input  rd_en, rd_addr, pk_valid, pk_value, pk_addr, pk_bin, busy, done
  );
endinterface

// File: rtl/peak_scan_sequencer.sv
// Per-bin scheduled peak search over the upper half of each range-bin spectrum.
//   state    | meaning
//   IDLE     | waiting for start
//   WAIT_BUF | waiting for the current bin's buffer to fill
//   SCAN     | issuing one read per cycle, points SCAN_START..N_PTS-1
//   DRAIN    | last read's data returns and is compared
//   OUTPUT   | result held on pk_* until accepted
module peak_scan_sequencer #(
  parameter int N_PTS      = 1024,
  parameter int SCAN_START = 512,
  parameter int DATA_W     = 32,
  parameter int BIN_W      = 5
) (
  input logic       clk,
  input logic       rst_n,
  peak_scan_if.slave bus
);
  localparam int PT_W = $clog2(N_PTS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUF,
    ST_SCAN,
    ST_DRAIN,
    ST_OUTPUT
  } state_t;

  state_t             state_q, state_nx;
  logic [PT_W-1:0]    point_q, point_nx;
  logic [BIN_W-1:0]   bin_q, bin_nx;
  logic [BIN_W-1:0]   cnt_q, cnt_nx;
  logic               done_nx;
  logic               clr_max;
  logic               last_bin;

  logic               rd_en_q;
  logic               pk_valid_q;
  logic               busy_q;
  logic               done_q;

  logic               cmp_vld_q;
  logic               cmp_first_q;
  logic [PT_W-1:0]    cmp_pt_q;
  logic [DATA_W-1:0]  max_q;
  logic [PT_W-1:0]    max_addr_q;

  assign last_bin = (bin_q == cnt_q - 1'b1);

  always_comb begin
    state_nx = state_q;
    point_nx = point_q;
    bin_nx   = bin_q;
    cnt_nx   = cnt_q;
    done_nx  = 1'b0;
    clr_max  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.bin_count != '0) begin
            cnt_nx   = bus.bin_count;
            bin_nx   = '0;
            state_nx = ST_WAIT_BUF;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      ST_WAIT_BUF: begin
        if (bus.buf_ready) begin
          point_nx = PT_W'(SCAN_START);
          clr_max  = 1'b1;
          state_nx = ST_SCAN;
        end
      end
      ST_SCAN: begin
        point_nx = point_q + 1'b1;
        if (point_q == PT_W'(N_PTS - 1)) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_nx = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (bus.pk_ready) begin
          if (last_bin) begin
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            bin_nx   = bin_q + 1'b1;
            state_nx = ST_WAIT_BUF;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // Abort wins over start and over a handshake in the same cycle.
    if (bus.abort) begin
      state_nx = ST_IDLE;
      point_nx = point_q;
      bin_nx   = bin_q;
      cnt_nx   = cnt_q;
      done_nx  = 1'b0;
      clr_max  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      point_q    <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      rd_en_q    <= 1'b0;
      pk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_nx;
      point_q    <= point_nx;
      bin_q      <= bin_nx;
      cnt_q      <= cnt_nx;
      rd_en_q    <= (state_nx == ST_SCAN);
      pk_valid_q <= (state_nx == ST_OUTPUT);
      busy_q     <= (state_nx != ST_IDLE);
      done_q     <= done_nx;
    end
  end

  // Compare stage: read data lags the issued address by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld_q   <= 1'b0;
      cmp_first_q <= 1'b0;
      cmp_pt_q    <= '0;
      max_q       <= '0;
      max_addr_q  <= '0;
    end else begin
      cmp_vld_q   <= rd_en_q;
      cmp_first_q <= (point_q == PT_W'(SCAN_START));
      cmp_pt_q    <= point_q;
      if (clr_max) begin
        max_q      <= '0;
        max_addr_q <= '0;
      end else if (cmp_vld_q && (cmp_first_q || (bus.rd_data > max_q))) begin
        max_q      <= bus.rd_data;
        max_addr_q <= cmp_pt_q;
      end
    end
  end

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = {bin_q, point_q};
  assign bus.pk_valid = pk_valid_q;
  assign bus.pk_value = max_q;
  assign bus.pk_addr  = max_addr_q;
  assign bus.pk_bin   = bin_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: doc/peak_scan_sequencer.md
# peak_scan_sequencer

Sequences the peak search over a multi-range-bin spectrum buffer. On `start`, it walks bins 0..bin_count-1 and, for each bin, waits until the bin's 1024-point buffer is filled. It then reads the upper half of the spectrum (points 512..1023), tracks the maximum and its point address, and hands each result downstream over a valid/ready handshake. It sits between the spectrum/accumulation RAM and the peak-result packer, replacing free-running peak detection with a controlled, per-bin scheduled scan.

## Interface
- N_PTS, 1024: points per range bin.
- SCAN_START, 512: first point scanned; points below it are never read.
- DATA_W, 32: spectrum sample width, unsigned.
- BIN_W, 5: range-bin index width.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a scan sequence when idle.
- abort  in  1  synchronous; cancels any sequence in progress.
- bin_count  in  BIN_W  number of bins to scan; latched on accepted `start`.
- buf_ready  in  1  level; buffer of current bin is filled and readable.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  BIN_W+10  {bin_idx, point}; read data returns exactly 1 cycle after rd_en.
- rd_data  in  DATA_W  buffer read data.
- pk_valid  out  1  peak result available.
- pk_ready  in  1  downstream accepts result.
- pk_value  out  DATA_W  bin maximum.
- pk_addr  out  10  point address of maximum (512..1023).
- pk_bin  out  BIN_W  bin index of result.
- busy  out  1  high whenever FSM is not IDLE.
- done  out  1  one-cycle pulse after last result accepted.

## Operation
- Reset: FSM=IDLE; all outputs 0; internal max, address and bin_idx cleared.
- FSM states are IDLE, WAIT_BUF, SCAN, DRAIN and OUTPUT.
- IDLE:
  - `start` with bin_count≥1: latch bin_count, bin_idx=0, go to WAIT_BUF.
  - `start` with bin_count=0: pulse `done` next cycle, stay IDLE.
- WAIT_BUF: stays until buf_ready=1, then point=SCAN_START and go to SCAN.
- SCAN:
  - rd_en=1 and rd_addr={bin_idx, point} every cycle; point increments each cycle.
  - After issuing point N_PTS-1, go to DRAIN. A bin takes exactly 512 reads.
- Compare stage: uses rd_data one cycle after each read, paired with the delayed point address.
  - The first sample of a bin loads max/addr unconditionally.
  - Later samples replace it only if strictly greater (unsigned). Ties keep the lowest address.
- DRAIN: one cycle; the final sample is compared. Go to OUTPUT.
- OUTPUT:
  - pk_valid=1 with pk_value/pk_addr/pk_bin held stable until pk_ready.
  - On handshake, if bin_idx = latched count-1: pk_valid drops, `done` pulses, go to IDLE.
  - Otherwise bin_idx+1 and go to WAIT_BUF.
- `start` while busy is ignored; bin_count changes while busy have no effect.
- `abort` (any non-IDLE state): IDLE next cycle, rd_en and pk_valid deassert, no `done`, no partial result emitted. abort has priority over start and the handshake in the same cycle.
- buf_ready is sampled only in WAIT_BUF; deassertion during SCAN is ignored.
- Max accumulator and address are cleared on entry to SCAN, so no value carries between bins.

## Timing
- Cycle 0: start sampled. Cycle 1: WAIT_BUF.
- With buf_ready=1 at cycle 1:
  - SCAN cycles 2..513 (rd_addr point 512..1023).
  - DRAIN at cycle 514.
  - pk_valid first high at cycle 515.
- Per bin with no stalls: 1 WAIT_BUF + 512 SCAN + 1 DRAIN + ≥1 OUTPUT = 515 cycles minimum.
- Handshake is complete on the rising edge where pk_valid & pk_ready are both high. The next bin's WAIT_BUF is in the following cycle.
- `done` is high for the one cycle after the final handshake; busy is low in that same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Asynchronous reset takes effect immediately; the first start is accepted on the first edge after rst_n is released.

## Test plan
- Single bin, bin_count=1, ramp data rd_data=point, pk_ready=1:
  - -> rd_addr 512..1023 in cycles 2..513.
  - -> pk_valid at 515 with pk_value=1023, pk_addr=1023, pk_bin=0.
  - -> done at 516.
- Ties: value 0x100 at points 600 and 900, all others 5.
  - -> pk_addr=600, pk_value=0x100.
  - Also: a huge value placed at point 100 is never read and does not affect the result.
- Multi-bin with backpressure: bin_count=3, pk_ready held low 10 cycles per result.
  - -> each result stable while stalled; pk_bin 0,1,2 in order; rd_addr upper bits track bin.
  - -> exactly one done pulse.
- buf_ready stall: buf_ready low 50 cycles in bin 1.
  - -> no rd_en during the stall; SCAN starts the cycle after buf_ready rises.
- bin_count=0 start -> done pulse, busy never high, no reads.
  - Also: start pulsed during SCAN is ignored.
- abort at cycle 300 of SCAN:
  - -> IDLE next cycle, no pk_valid, no done.
  - A new start afterwards yields correct results.
- rst_n asserted mid-OUTPUT -> all outputs 0 immediately.
